// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: shares one I2C master core between N_REQ requesters.
// Each request is a single register read or write. Requesters are served
// round-robin, NACKed transfers are retried, and every attempt is bounded by
// a timeout that aborts the master.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | no owner; pick next requester at/after rr_ptr and latch cmd
// S_ISSUE     | owner granted; wait for m_busy low, then pulse m_start
// S_WAIT_DONE | transfer in flight; count cycles, handle done/nack/timeout
// S_RESP      | one-cycle rsp_valid to owner, advance rr_ptr, release grant
module i2c_txn_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 200000,
  parameter int MAX_RETRY   = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [N_REQ-1:0]   req_rw_i,
  input  logic [7*N_REQ-1:0] req_slave_addr_i,
  input  logic [8*N_REQ-1:0] req_reg_addr_i,
  input  logic [8*N_REQ-1:0] req_wdata_i,
  output logic [N_REQ-1:0]   rsp_valid_o,
  output logic [7:0]         rsp_rdata_o,
  output logic               rsp_err_o,
  output logic               rsp_timeout_o,
  output logic [N_REQ-1:0]   grant_o,
  output logic               m_start_o,
  output logic               m_rw_o,
  output logic [6:0]         m_slave_addr_o,
  output logic [7:0]         m_reg_addr_o,
  output logic [7:0]         m_wdata_o,
  output logic               m_abort_o,
  input  logic               m_busy_i,
  input  logic               m_done_i,
  input  logic               m_nack_i,
  input  logic [7:0]         m_rdata_i
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  // A zero-retry build still needs a one-bit counter to keep the compare legal.
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [TW-1:0]    TIMER_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [RW-1:0]    RETRY_MAX  = RW'(MAX_RETRY);
  localparam logic [N_REQ-1:0] GRANT_ONE  = N_REQ'(1);
  localparam logic [IW-1:0]    LAST_IDX   = IW'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_RESP      = 2'd3
  } state_t;

  state_t           state_q;
  logic [IW-1:0]    rr_ptr_q;
  logic [IW-1:0]    grant_idx_q;
  logic [TW-1:0]    timer_q;
  logic [RW-1:0]    retry_q;
  logic [N_REQ-1:0] grant_q;
  logic [N_REQ-1:0] rsp_valid_q;
  logic [7:0]       rsp_rdata_q;
  logic             rsp_err_q;
  logic             rsp_timeout_q;
  logic             m_start_q;
  logic             m_rw_q;
  logic [6:0]       m_slave_addr_q;
  logic [7:0]       m_reg_addr_q;
  logic [7:0]       m_wdata_q;
  logic             m_abort_q;

  logic             pick_valid_d;
  logic [IW-1:0]    pick_idx_d;
  logic [6:0]       sel_slave_addr;
  logic [7:0]       sel_reg_addr;
  logic [7:0]       sel_wdata;

  // Round-robin pick: scan offsets from far to near so the nearest set bit
  // at or after rr_ptr is the last (winning) assignment.
  always_comb begin
    int j;
    j            = 0;
    pick_valid_d = 1'b0;
    pick_idx_d   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = int'(rr_ptr_q) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (req_i[IW'(j)]) begin
        pick_valid_d = 1'b1;
        pick_idx_d   = IW'(j);
      end
    end
  end

  assign sel_slave_addr = 7'(req_slave_addr_i >> (7 * int'(pick_idx_d)));
  assign sel_reg_addr   = 8'(req_reg_addr_i >> (8 * int'(pick_idx_d)));
  assign sel_wdata      = 8'(req_wdata_i >> (8 * int'(pick_idx_d)));

  // Transaction sequencer with all handshake and response outputs registered.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= S_IDLE;
      rr_ptr_q       <= '0;
      grant_idx_q    <= '0;
      timer_q        <= '0;
      retry_q        <= '0;
      grant_q        <= '0;
      rsp_valid_q    <= '0;
      rsp_rdata_q    <= '0;
      rsp_err_q      <= 1'b0;
      rsp_timeout_q  <= 1'b0;
      m_start_q      <= 1'b0;
      m_rw_q         <= 1'b0;
      m_slave_addr_q <= '0;
      m_reg_addr_q   <= '0;
      m_wdata_q      <= '0;
      m_abort_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_valid_d) begin
            grant_q        <= GRANT_ONE << pick_idx_d;
            grant_idx_q    <= pick_idx_d;
            m_rw_q         <= req_rw_i[pick_idx_d];
            m_slave_addr_q <= sel_slave_addr;
            m_reg_addr_q   <= sel_reg_addr;
            m_wdata_q      <= sel_wdata;
            retry_q        <= '0;
            state_q        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!m_busy_i) begin
            m_start_q <= 1'b1;
            timer_q   <= '0;
            state_q   <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          m_start_q <= 1'b0;
          timer_q   <= timer_q + TW'(1);
          // m_done is checked first so a completion on the last cycle wins.
          if (m_done_i) begin
            if (m_nack_i && (retry_q < RETRY_MAX)) begin
              retry_q <= retry_q + RW'(1);
              state_q <= S_ISSUE;
            end else begin
              rsp_rdata_q   <= m_rw_q ? 8'h00 : m_rdata_i;
              rsp_err_q     <= m_nack_i;
              rsp_timeout_q <= 1'b0;
              rsp_valid_q   <= grant_q;
              state_q       <= S_RESP;
            end
          end else if (timer_q == TIMER_LAST) begin
            m_abort_q     <= 1'b1;
            rsp_rdata_q   <= 8'h00;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= grant_q;
            state_q       <= S_RESP;
          end
        end
        S_RESP: begin
          rsp_valid_q <= '0;
          m_abort_q   <= 1'b0;
          grant_q     <= '0;
          rr_ptr_q    <= (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + IW'(1);
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_rdata_o    = rsp_rdata_q;
  assign rsp_err_o      = rsp_err_q;
  assign rsp_timeout_o  = rsp_timeout_q;
  assign grant_o        = grant_q;
  assign m_start_o      = m_start_q;
  assign m_rw_o         = m_rw_q;
  assign m_slave_addr_o = m_slave_addr_q;
  assign m_reg_addr_o   = m_reg_addr_q;
  assign m_wdata_o      = m_wdata_q;
  assign m_abort_o      = m_abort_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Bench for i2c_txn_arbiter: directed scenarios followed by randomized
// transactions, checked against a transaction-level reference model.
module tb_i2c_txn_arbiter;

  localparam int N  = 4;
  localparam int TO = 100;
  localparam int MR = 2;

  typedef enum int {P_ACK, P_NACK, P_HANG} beh_t;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic [N-1:0]     req_i, req_rw_i;
  logic [7*N-1:0]   req_slave_addr_i;
  logic [8*N-1:0]   req_reg_addr_i, req_wdata_i;
  logic [N-1:0]     rsp_valid_o, grant_o;
  logic [7:0]       rsp_rdata_o;
  logic             rsp_err_o, rsp_timeout_o;
  logic             m_start_o, m_rw_o, m_abort_o;
  logic [6:0]       m_slave_addr_o;
  logic [7:0]       m_reg_addr_o, m_wdata_o;
  logic             m_busy_i, m_done_i, m_nack_i;
  logic [7:0]       m_rdata_i;

  i2c_txn_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO), .MAX_RETRY(MR)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_i(req_i), .req_rw_i(req_rw_i),
    .req_slave_addr_i(req_slave_addr_i), .req_reg_addr_i(req_reg_addr_i),
    .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .grant_o(grant_o), .m_start_o(m_start_o), .m_rw_o(m_rw_o),
    .m_slave_addr_o(m_slave_addr_o), .m_reg_addr_o(m_reg_addr_o),
    .m_wdata_o(m_wdata_o), .m_abort_o(m_abort_o),
    .m_busy_i(m_busy_i), .m_done_i(m_done_i), .m_nack_i(m_nack_i),
    .m_rdata_i(m_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_starts = 0, exp_aborts = 0;
  int mon_starts = 0, mon_aborts = 0;

  // requester-side model
  bit         pend[N];
  bit         rw_a[N];
  logic [6:0] sa[N];
  logic [7:0] ra[N], wd[N];
  int         rr;

  // master behaviour plan for one transaction
  beh_t       plan_b[MR+1];
  int         plan_d[MR+1];
  logic [7:0] plan_rd[MR+1];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    if (!reset_i) begin
      check_val("grant_onehot0", 32'($onehot0(grant_o)), 32'd1);
      if (m_start_o) mon_starts++;
      if (m_abort_o) mon_aborts++;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_req();
    for (int i = 0; i < N; i++) begin
      req_i[i]                 = pend[i];
      req_rw_i[i]              = rw_a[i];
      req_slave_addr_i[7*i+:7] = sa[i];
      req_reg_addr_i[8*i+:8]   = ra[i];
      req_wdata_i[8*i+:8]      = wd[i];
    end
  endtask

  task automatic raise(input int i);
    pend[i] = 1'b1;
    rw_a[i] = 1'($urandom);
    sa[i]   = 7'($urandom);
    ra[i]   = 8'($urandom);
    wd[i]   = 8'($urandom);
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++)
      if (pend[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  // Outcome of a transaction from the plan: attempts run until an ACK, a
  // hang (timeout), or a NACK with no retries left.
  task automatic ref_model(input bit rw, output int att, output bit err,
                           output bit to, output logic [7:0] rd);
    att = 0; err = 1'b0; to = 1'b0; rd = 8'h00;
    for (int i = 0; i <= MR; i++) begin
      att = i + 1;
      if (plan_b[i] == P_HANG) begin
        err = 1'b1; to = 1'b1; rd = 8'h00;
        return;
      end
      rd  = rw ? 8'h00 : plan_rd[i];
      err = (plan_b[i] == P_NACK);
      if (!err) return;
    end
  endtask

  task automatic set_plan(input int i, input beh_t b, input int d, input logic [7:0] rd);
    plan_b[i] = b; plan_d[i] = d; plan_rd[i] = rd;
  endtask

  task automatic rand_plan();
    int r;
    for (int i = 0; i <= MR; i++) begin
      r = $urandom_range(0, 11);
      plan_b[i]  = (r == 0) ? P_HANG : (r < 4) ? P_NACK : P_ACK;
      plan_d[i]  = ($urandom_range(0, 7) == 0) ? TO - 1 : $urandom_range(0, 50);
      plan_rd[i] = 8'($urandom);
    end
  endtask

  task automatic chk_zero(input string pfx);
    check_val({pfx, "_grant"}, 32'(grant_o), 0);
    check_val({pfx, "_rsp_valid"}, 32'(rsp_valid_o), 0);
    check_val({pfx, "_rsp_rdata"}, 32'(rsp_rdata_o), 0);
    check_val({pfx, "_rsp_err"}, 32'(rsp_err_o), 0);
    check_val({pfx, "_rsp_timeout"}, 32'(rsp_timeout_o), 0);
    check_val({pfx, "_m_start"}, 32'(m_start_o), 0);
    check_val({pfx, "_m_abort"}, 32'(m_abort_o), 0);
    check_val({pfx, "_m_cmd"}, {8'(m_rw_o), 8'(m_slave_addr_o), m_reg_addr_o, m_wdata_o}, 0);
  endtask

  task automatic do_reset();
    reset_i  = 1'b1;
    m_busy_i = 1'b0;
    m_done_i = 1'b0;
    repeat (2) tick();
    chk_zero("reset");
    reset_i = 1'b0;
    rr      = 0;
  endtask

  // From an IDLE cycle: advance to the ISSUE cycle, sometimes with a stray
  // m_done that must be ignored.
  task automatic launch(output int w);
    w = pick();
    check_val("pending_exists", 32'(w >= 0), 1);
    if ($urandom_range(0, 3) == 0) begin
      m_done_i = 1'b1;
      m_nack_i = 1'($urandom);
    end
    tick();
    m_done_i = 1'b0;
  endtask

  task automatic issue_phase(input bit crw, input logic [6:0] csa,
                             input logic [7:0] cra, input logic [7:0] cwd);
    int b;
    b = $urandom_range(0, 3);
    m_busy_i = (b > 0);
    for (int k = 0; k <= b; k++) begin
      check_val("start_held_low", 32'(m_start_o), 0);
      if (k == b) m_busy_i = 1'b0;
      tick();
    end
    check_val("m_start", 32'(m_start_o), 1);
    check_val("m_cmd", {8'(m_rw_o), 8'(m_slave_addr_o), m_reg_addr_o, m_wdata_o},
              {8'(crw), 8'(csa), cra, cwd});
    exp_starts++;
    m_busy_i = 1'b1;
  endtask

  // Entered in the ISSUE cycle of requester w; returns in the following IDLE cycle.
  task automatic run_txn(input int w);
    bit         crw;
    logic [6:0] csa;
    logic [7:0] cra, cwd;
    int         e_att, n_att;
    bit         e_err, e_to;
    logic [7:0] e_rd;
    crw = rw_a[w]; csa = sa[w]; cra = ra[w]; cwd = wd[w];
    ref_model(crw, e_att, e_err, e_to, e_rd);
    check_val("grant", 32'(grant_o), 32'd1 << w);
    check_val("latched_cmd", {8'(m_rw_o), 8'(m_slave_addr_o), m_reg_addr_o, m_wdata_o},
              {8'(crw), 8'(csa), cra, cwd});
    if ($urandom_range(0, 3) == 0) begin
      rw_a[w] = ~rw_a[w]; sa[w] = ~sa[w]; ra[w] = ~ra[w]; wd[w] = ~wd[w];
      drive_req();
    end
    if ($urandom_range(0, 4) == 0) begin
      pend[w] = 1'b0;
      drive_req();
    end
    n_att = 0;
    for (int i = 0; i <= MR; i++) begin
      issue_phase(crw, csa, cra, cwd);
      n_att++;
      if (plan_b[i] == P_HANG) begin
        for (int t = 1; t <= TO; t++) begin
          tick();
          if (t < TO) check_val("abort_early", 32'(m_abort_o), 0);
        end
        m_busy_i = 1'b0;
        exp_aborts++;
        check_val("m_abort", 32'(m_abort_o), 1);
        break;
      end
      for (int t = 0; t < plan_d[i]; t++) begin
        tick();
        if (t == 0) check_val("start_pulse_width", 32'(m_start_o), 0);
      end
      m_done_i  = 1'b1;
      m_nack_i  = (plan_b[i] == P_NACK);
      m_rdata_i = plan_rd[i];
      tick();
      m_done_i  = 1'b0;
      m_nack_i  = 1'($urandom);
      m_rdata_i = 8'($urandom);
      m_busy_i  = 1'b0;
      check_val("no_abort", 32'(m_abort_o), 0);
      if (plan_b[i] == P_NACK && i < MR) begin
        check_val("no_rsp_on_retry", 32'(rsp_valid_o), 0);
        continue;
      end
      break;
    end
    check_val("attempts", 32'(n_att), 32'(e_att));
    check_val("rsp_valid", 32'(rsp_valid_o), 32'd1 << w);
    check_val("rsp_rdata", 32'(rsp_rdata_o), 32'(e_rd));
    check_val("rsp_err", 32'(rsp_err_o), 32'(e_err));
    check_val("rsp_timeout", 32'(rsp_timeout_o), 32'(e_to));
    check_val("grant_in_resp", 32'(grant_o), 32'd1 << w);
    pend[w] = 1'b0;
    drive_req();
    rr = (w + 1) % N;
    tick();
    check_val("idle_grant", 32'(grant_o), 0);
    check_val("idle_rsp_valid", 32'(rsp_valid_o), 0);
    check_val("idle_abort", 32'(m_abort_o), 0);
    check_val("rsp_hold", {8'(rsp_err_o), 8'(rsp_timeout_o), rsp_rdata_o},
              {8'(e_err), 8'(e_to), e_rd});
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drive_req();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    reset_i = 1'b1; m_busy_i = 1'b0; m_done_i = 1'b0; m_nack_i = 1'b0; m_rdata_i = 8'h00;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; rw_a[i] = 1'b0; sa[i] = '0; ra[i] = '0; wd[i] = '0;
    end
    drive_req();
    rr = 0;
    do_reset();

    // single write from requester 0, ACK after 40 cycles
    pend[0] = 1'b1; rw_a[0] = 1'b1; sa[0] = 7'h55; ra[0] = 8'hEB; wd[0] = 8'hAD;
    drive_req();
    set_plan(0, P_ACK, 40, 8'h77); set_plan(1, P_ACK, 1, 8'h00); set_plan(2, P_ACK, 1, 8'h00);
    launch(w); run_txn(w);

    // all four held: rotation 0,1,2,3,0
    clear_reqs(); do_reset();
    for (int i = 0; i < N; i++) raise(i);
    drive_req();
    for (int j = 0; j < 5; j++) begin
      for (int i = 0; i <= MR; i++) set_plan(i, P_ACK, $urandom_range(0, 20), 8'($urandom));
      launch(w); run_txn(w);
      raise(w); drive_req();
    end

    // read from requester 2 returning 0x3C
    clear_reqs(); do_reset();
    raise(2); rw_a[2] = 1'b0; drive_req();
    set_plan(0, P_ACK, 12, 8'h3C);
    launch(w); run_txn(w);

    // NACK every attempt
    raise(1); drive_req();
    for (int i = 0; i <= MR; i++) set_plan(i, P_NACK, 5 + i, 8'($urandom));
    launch(w); run_txn(w);

    // timeout, then completions on the last allowed cycle
    raise(3); drive_req();
    set_plan(0, P_HANG, 0, 8'h00);
    launch(w); run_txn(w);
    raise(0); drive_req();
    set_plan(0, P_ACK, TO - 1, 8'h5A);
    launch(w); run_txn(w);
    raise(1); drive_req();
    for (int i = 0; i <= MR; i++) set_plan(i, P_NACK, TO - 1, 8'($urandom));
    launch(w); run_txn(w);

    // reset mid-transfer, then requester 0 beats pending 3
    clear_reqs(); do_reset();
    raise(3); drive_req();
    launch(w);
    check_val("rst_case_grant", 32'(grant_o), 32'b1000);
    m_busy_i = 1'b0;
    tick();
    check_val("rst_case_start", 32'(m_start_o), 1);
    exp_starts++;
    m_busy_i = 1'b1;
    repeat (10) tick();
    raise(0); drive_req();
    reset_i = 1'b1;
    tick();
    chk_zero("reset_mid");
    reset_i  = 1'b0;
    m_busy_i = 1'b0;
    rr       = 0;
    rand_plan();
    launch(w);
    run_txn(w);

    // randomized traffic
    for (int it = 0; it < 60; it++) begin
      if (pick() < 0) raise($urandom_range(0, N - 1));
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 2) == 0) raise(i);
      drive_req();
      rand_plan();
      launch(w);
      run_txn(w);
    end

    check_val("start_count", 32'(mon_starts), 32'(exp_starts));
    check_val("abort_count", 32'(mon_aborts), 32'(exp_aborts));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
